// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the I/D cache memory arbiter: FSM states, grant side, defaults.
package mem_arbiter_pkg;

    localparam int LINE_W_DEF  = 256;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_D = 2'd1,
        ST_SERVE_I = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_pick.sv
// Two-way winner select, combinational: D wins unless D won last time and I is waiting.
// No backpressure; o_vld only says that some requester is asking.
module rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic   i_ic_req,
    input  logic   i_dc_req,
    input  grant_e i_last_grant,
    output logic   o_vld,
    output grant_e o_grant
);

    always_comb begin
        o_vld   = i_ic_req | i_dc_req;
        o_grant = GNT_I;
        if (i_dc_req && !(i_last_grant == GNT_D && i_ic_req)) begin
            o_grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache line misses onto one memory port; grant one edge after req, ack one edge after mem_ack.
// Requesters hold req until their ack; the core is stalled through hold_o while anything is pending.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_we,
    input  logic [LINE_W-1:0] dc_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              ic_ack,
    output logic              dc_ack,
    output logic [LINE_W-1:0] rdata,
    output logic              hold_o,
    output logic              err_o
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e            r_state;
    state_e            w_state_nxt;
    grant_e            r_last_grant;
    grant_e            w_pick;
    logic              w_pick_vld;
    logic              w_grant;
    logic              w_ack_take;
    logic              w_serving;
    logic [CNT_W-1:0]  w_cnt_inc;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [LINE_W-1:0] r_mem_wdata;
    logic              r_ic_ack;
    logic              r_dc_ack;
    logic [LINE_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_wait_cnt;

    rr_pick u_rr_pick (
        .i_ic_req     (ic_req),
        .i_dc_req     (dc_req),
        .i_last_grant (r_last_grant),
        .o_vld        (w_pick_vld),
        .o_grant      (w_pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE is a dead cycle so a requester dropping req on its ack is never re-granted.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (w_pick == GNT_D) ? ST_SERVE_D : ST_SERVE_I;
                end
            end
            ST_SERVE_D, ST_SERVE_I: begin
                if (mem_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_serving = (r_state == ST_SERVE_D) || (r_state == ST_SERVE_I);
    assign w_cnt_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= GNT_I;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_ic_ack     <= 1'b0;
            r_dc_ack     <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_ic_ack <= 1'b0;
            r_dc_ack <= 1'b0;
            if (w_grant) begin
                r_mem_req    <= 1'b1;
                r_wait_cnt   <= '0;
                r_last_grant <= w_pick;
                if (w_pick == GNT_D) begin
                    r_mem_addr  <= dc_addr;
                    r_mem_we    <= dc_we;
                    r_mem_wdata <= dc_wdata;
                end else begin
                    r_mem_addr <= ic_addr;
                    r_mem_we   <= 1'b0;
                end
            end else if (w_ack_take) begin
                r_mem_req <= 1'b0;
                r_rdata   <= mem_rdata;
                if (r_state == ST_SERVE_D) begin
                    r_dc_ack <= 1'b1;
                end else begin
                    r_ic_ack <= 1'b1;
                end
            end else if (w_serving) begin
                // Timeout only flags; the transaction keeps waiting for its ack.
                r_wait_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign ic_ack    = r_ic_ack;
    assign dc_ack    = r_dc_ack;
    assign rdata     = r_rdata;
    assign err_o     = r_err;
    assign hold_o    = ic_req | dc_req | w_serving;

endmodule
